// File: rtl/fetch_prefetch_if.sv
// Fetch front-end bus bundle: CCM read port plus the decode-side valid/ready handshake.
// The master side is the fetch unit; the slave side is the memory/decode environment.
interface fetch_prefetch_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_valid;
    logic                  if_valid;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;

    modport master (
        output mem_rd, mem_rd_addr, if_valid, if_instr, if_pc,
        input  mem_rd_data, mem_rd_valid, if_ready
    );

    modport slave (
        input  mem_rd, mem_rd_addr, if_valid, if_instr, if_pc,
        output mem_rd_data, mem_rd_valid, if_ready
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch with prefetch buffer: keeps up to FIFO_DEPTH CCM reads in flight, buffers
// returned words with their PC, and discards stale responses after a redirect.
//
// state  | meaning
// IDLE   | fetch disabled, nothing in flight
// FETCH  | issuing reads / receiving responses
// FLUSH  | stale responses from before a redirect still pending (drop_cnt > 0)
module fetch_prefetch #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    fetch_prefetch_if.master      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] buf_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc    [FIFO_DEPTH];

    logic          issue;
    logic          resp;
    logic          dropping;
    logic          keep;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_next;

    // Credit covers both in-flight reads and buffered entries, so a response always has a slot.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign issue       = rst_n & fetch_en & ~redirect_valid & (credit_used < DEPTH_SUM);
    assign resp        = bus.mem_rd_valid;
    assign dropping    = resp & (drop_cnt != '0);
    assign keep        = resp & ~redirect_valid & (drop_cnt == '0);
    assign pop         = bus.if_valid & bus.if_ready;

    assign outstanding_next = outstanding + CW'(issue) - CW'(resp);

    // On redirect every read surviving this edge is stale; drop_cnt never exceeds outstanding.
    always_comb begin
        drop_next = drop_cnt - CW'(dropping);
        if (redirect_valid) begin
            drop_next = outstanding - CW'(resp);
        end
    end

    assign bus.mem_rd      = issue;
    assign bus.mem_rd_addr = fetch_pc;
    assign bus.if_valid    = (count != '0);
    assign bus.if_instr    = (count != '0) ? buf_instr[rd_ptr] : '0;
    assign bus.if_pc       = (count != '0) ? buf_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
                resp_pc  <= redirect_addr;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 1'b1;
                if (keep) begin
                    resp_pc <= resp_pc + 1'b1;
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(keep) - CW'(pop);
            end
            case (state)
                S_IDLE:  if (fetch_en) state <= S_FETCH;
                S_FETCH: begin
                    if (drop_next != '0)                       state <= S_FLUSH;
                    else if (!fetch_en && outstanding == '0)   state <= S_IDLE;
                end
                S_FLUSH: if (drop_next == '0) state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            buf_instr[wr_ptr] <= bus.mem_rd_data;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

    credit_ok: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.mem_rd_valid && count == DEPTH_CNT));

endmodule
